// File: rtl/analyze_run_ctrl.sv
// Run-level sequencer for the readout analysis path: gates num_shots samples
// through a small FIFO to the selected engine and tallies classifier verdicts.
module analyze_run_ctrl #(
    parameter int SHOT_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        analyze_mode,
    input  logic [SHOT_W-1:0] num_shots,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] i_val,
    input  logic [DATA_W-1:0] q_val,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_i,
    output logic [DATA_W-1:0] m_q,
    output logic [1:0]        m_mode,
    input  logic              cls_valid,
    input  logic [1:0]        cls_result,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              mode_err,
    output logic [SHOT_W-1:0] shots_in,
    output logic [SHOT_W-1:0] excited_cnt,
    output logic [SHOT_W-1:0] ground_cnt,
    output logic [SHOT_W-1:0] online_cnt
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_r, state_next_s;
    logic [1:0]          mode_r;
    logic [SHOT_W-1:0]   num_shots_r, shots_in_r, excited_r, ground_r, online_r;
    logic [DATA_W-1:0]   fifo_i_r [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_q_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                done_r, aborted_r, mode_err_r;
    logic                s_ready_s, busy_s;
    logic [SHOT_W+1:0]   tally_sum_s;

    function automatic logic [SHOT_W-1:0] sat_inc(input logic [SHOT_W-1:0] v);
        sat_inc = (v == {SHOT_W{1'b1}}) ? v : v + SHOT_W'(1);
    endfunction

    wire fifo_empty_s = (count_r == {CNT_W{1'b0}});
    wire fifo_full_s  = (count_r == CNT_W'(FIFO_DEPTH));
    wire idle_s       = (state_r == ST_IDLE);
    wire start_ok_s   = idle_s && start && !abort && (analyze_mode != 2'b10);
    wire start_bad_s  = idle_s && start && !abort && (analyze_mode == 2'b10);
    wire zero_shots_s = (num_shots == {SHOT_W{1'b0}});
    wire push_s       = s_valid && s_ready_s && !abort;
    wire pop_s        = !fifo_empty_s && m_ready && !abort;
    wire classify_s   = (mode_r == 2'b01);
    wire tally_s      = cls_valid && busy_s && classify_s && !abort;

    assign tally_sum_s = {2'b00, excited_r} + {2'b00, ground_r} + {2'b00, online_r};
    wire drain_ok_s = fifo_empty_s && (!classify_s || (tally_sum_s == {2'b00, num_shots_r}));

    // State register
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = (start_ok_s && !zero_shots_s) ? ST_RUN : ST_IDLE;
                ST_RUN:   state_next_s = (shots_in_r == num_shots_r) ? ST_DRAIN : ST_RUN;
                ST_DRAIN: state_next_s = drain_ok_s ? ST_DONE : ST_DRAIN;
                ST_DONE:  state_next_s = ST_IDLE;
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs; s_ready never looks at m_ready
    always_comb begin
        s_ready_s = 1'b0;
        busy_s    = 1'b0;
        if (state_r == ST_RUN) begin
            s_ready_s = !fifo_full_s && (shots_in_r < num_shots_r);
            busy_s    = 1'b1;
        end else if (state_r == ST_DRAIN) begin
            busy_s    = 1'b1;
        end else begin
            s_ready_s = 1'b0;
            busy_s    = 1'b0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk100) begin
        if (reset || abort) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents are masked at the output while empty
    always_ff @(posedge clk100) begin
        if (push_s) begin
            fifo_i_r[wr_ptr_r] <= i_val;
            fifo_q_r[wr_ptr_r] <= q_val;
        end
    end

    // Run configuration, shot counter and classifier tallies
    always_ff @(posedge clk100) begin
        if (reset) begin
            mode_r      <= 2'b00;
            num_shots_r <= {SHOT_W{1'b0}};
            shots_in_r  <= {SHOT_W{1'b0}};
            excited_r   <= {SHOT_W{1'b0}};
            ground_r    <= {SHOT_W{1'b0}};
            online_r    <= {SHOT_W{1'b0}};
            mode_err_r  <= 1'b0;
        end else if (start_ok_s) begin
            mode_r      <= analyze_mode;
            num_shots_r <= num_shots;
            shots_in_r  <= {SHOT_W{1'b0}};
            excited_r   <= {SHOT_W{1'b0}};
            ground_r    <= {SHOT_W{1'b0}};
            online_r    <= {SHOT_W{1'b0}};
            mode_err_r  <= 1'b0;
        end else begin
            if (start_bad_s) begin
                mode_err_r <= 1'b1;
            end
            if (push_s) begin
                shots_in_r <= sat_inc(shots_in_r);
            end
            if (tally_s) begin
                case (cls_result)
                    2'b01:   excited_r <= sat_inc(excited_r);
                    2'b10:   ground_r  <= sat_inc(ground_r);
                    2'b00:   online_r  <= sat_inc(online_r);
                    default: online_r  <= online_r;
                endcase
            end
        end
    end

    // Completion and abort pulses
    always_ff @(posedge clk100) begin
        if (reset) begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            aborted_r <= abort && !idle_s;
            done_r    <= !abort && (((state_r == ST_DRAIN) && drain_ok_s) ||
                                    (start_ok_s && zero_shots_s));
        end
    end

    assign s_ready     = s_ready_s;
    assign busy        = busy_s;
    assign m_valid     = !fifo_empty_s;
    assign m_i         = fifo_empty_s ? {DATA_W{1'b0}} : fifo_i_r[rd_ptr_r];
    assign m_q         = fifo_empty_s ? {DATA_W{1'b0}} : fifo_q_r[rd_ptr_r];
    assign m_mode      = mode_r;
    assign done        = done_r;
    assign aborted     = aborted_r;
    assign mode_err    = mode_err_r;
    assign shots_in    = shots_in_r;
    assign excited_cnt = excited_r;
    assign ground_cnt  = ground_r;
    assign online_cnt  = online_r;

endmodule

// File: tb/tb_analyze_run_ctrl.sv
// Directed bench for analyze_run_ctrl: a scoreboard queue holds every accepted
// sample and is compared against the engine-side output in order.
module tb_analyze_run_ctrl;
    logic        clk100 = 1'b0;
    logic        reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [1:0]  analyze_mode = 2'b00;
    logic [15:0] num_shots = 16'd0;
    logic        s_valid = 1'b0, s_ready;
    logic [31:0] i_val = 32'd0, q_val = 32'd0;
    logic        m_valid, m_ready = 1'b0;
    logic [31:0] m_i, m_q;
    logic [1:0]  m_mode;
    logic        cls_valid = 1'b0;
    logic [1:0]  cls_result = 2'b00;
    logic        busy, done, aborted, mode_err;
    logic [15:0] shots_in, excited_cnt, ground_cnt, online_cnt;

    int checks = 0, failures = 0;
    int acc_cnt, out_cnt, done_cnt, abt_cnt, idx, base;
    logic acc_s, pop_s;
    logic [31:0] last_i;
    logic [63:0] sb[$];

    always #5 clk100 = ~clk100;

    analyze_run_ctrl #(.SHOT_W(16), .FIFO_DEPTH(4), .DATA_W(32)) dut (
        .clk100(clk100), .reset(reset), .start(start), .abort(abort),
        .analyze_mode(analyze_mode), .num_shots(num_shots),
        .s_valid(s_valid), .s_ready(s_ready), .i_val(i_val), .q_val(q_val),
        .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q), .m_mode(m_mode),
        .cls_valid(cls_valid), .cls_result(cls_result),
        .busy(busy), .done(done), .aborted(aborted), .mode_err(mode_err),
        .shots_in(shots_in), .excited_cnt(excited_cnt), .ground_cnt(ground_cnt),
        .online_cnt(online_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_data();
        i_val = 32'(base + idx);
        q_val = 32'(-(base + idx));
    endtask

    task automatic clear_counts();
        acc_cnt = 0; out_cnt = 0; done_cnt = 0; abt_cnt = 0; idx = 0;
        set_data();
    endtask

    // One clock: log handshakes before the edge, sample pulses 1 time unit after.
    task automatic cycle();
        acc_s = s_valid && s_ready && !abort && !reset;
        pop_s = m_valid && m_ready && !abort && !reset;
        if (pop_s) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("out_data", {m_i, m_q}, sb.pop_front());
            out_cnt++;
        end
        if (acc_s) begin
            sb.push_back({i_val, q_val});
            last_i = i_val;
            acc_cnt++;
        end
        @(posedge clk100);
        #1;
        if (done) done_cnt++;
        if (aborted) abt_cnt++;
        if (acc_s) begin
            idx++;
            set_data();
        end
    endtask

    task automatic do_start(input logic [1:0] mode, input logic [15:0] n);
        start = 1'b1; analyze_mode = mode; num_shots = n;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt != 0) break;
            cycle();
        end
        for (int k = 0; k < 3; k++) cycle();
    endtask

    initial begin
        int both, changes;
        logic [31:0] held;
        base = 0;
        clear_counts();
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        chk("rst_outputs", {s_ready, m_valid, busy, done, aborted, mode_err, m_mode}, 64'd0);
        chk("rst_data", {m_i, m_q}, 64'd0);
        chk("rst_counters", {shots_in, excited_cnt, ground_cnt, online_cnt}, 64'd0);

        // Dump mode, three shots, free-flowing engine
        base = 1; clear_counts();
        m_ready = 1'b1; s_valid = 1'b1;
        do_start(2'b00, 16'd3);
        chk("t1_mode", 64'(m_mode), 64'd0);
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (acc_s) begin
                chk("t1_latency_valid", 64'(m_valid), 64'd1);
                chk("t1_latency_i", 64'(m_i), 64'(last_i));
            end
        end
        chk("t1_accepts", 64'(acc_cnt), 64'd3);
        chk("t1_outputs", 64'(out_cnt), 64'd3);
        chk("t1_done_pulses", 64'(done_cnt), 64'd1);
        chk("t1_shots_in", 64'(shots_in), 64'd3);
        chk("t1_idle", {s_ready, busy, m_valid}, 64'd0);
        s_valid = 1'b0;

        // Classify: completion waits for the fourth verdict
        base = 50; clear_counts();
        s_valid = 1'b1;
        do_start(2'b01, 16'd4);
        for (int k = 0; k < 10; k++) cycle();
        s_valid = 1'b0;
        chk("t2_accepts", 64'(acc_cnt), 64'd4);
        chk("t2_drained", 64'(sb.size()), 64'd0);
        chk("t2_still_busy", 64'(busy), 64'd1);
        cls_valid = 1'b1;
        cls_result = 2'b01; cycle();
        cls_result = 2'b11; cycle();
        cls_result = 2'b10; cycle();
        cls_result = 2'b01; cycle();
        cls_valid = 1'b0; cycle();
        chk("t2_no_early_done", 64'(done_cnt), 64'd0);
        cls_valid = 1'b1; cls_result = 2'b00; cycle();
        cls_valid = 1'b0;
        wait_done(10);
        chk("t2_done_pulses", 64'(done_cnt), 64'd1);
        chk("t2_tallies", {excited_cnt, ground_cnt, online_cnt}, {16'd2, 16'd1, 16'd1});

        // Hist2d with a stalled engine: FIFO fills, head holds
        base = 100; clear_counts();
        m_ready = 1'b0; s_valid = 1'b1;
        do_start(2'b11, 16'd8);
        changes = 0; held = 32'd0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 0) held = m_i;
            else if (m_i !== held) changes++;
        end
        chk("t3_stall_accepts", 64'(acc_cnt), 64'd4);
        chk("t3_s_ready_low", 64'(s_ready), 64'd0);
        chk("t3_head_first", 64'(held), 64'd100);
        chk("t3_head_changes", 64'(changes), 64'd0);
        m_ready = 1'b1;
        wait_done(40);
        s_valid = 1'b0;
        chk("t3_outputs", 64'(out_cnt), 64'd8);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);
        chk("t3_done_pulses", 64'(done_cnt), 64'd1);
        chk("t3_mode", 64'(m_mode), 64'd3);

        // Illegal mode, then a zero-shot legal start
        clear_counts();
        do_start(2'b10, 16'd5);
        chk("t4_mode_err_set", 64'(mode_err), 64'd1);
        chk("t4_stays_idle", {busy, s_ready}, 64'd0);
        do_start(2'b00, 16'd0);
        chk("t4_mode_err_clr", 64'(mode_err), 64'd0);
        chk("t4_zero_done", {done, busy}, 64'b10);
        chk("t4_cleared", 64'(shots_in), 64'd0);
        cycle();
        chk("t4_done_once", {done, busy}, 64'd0);

        // Abort after two accepts, colliding with start and a push
        base = 200; clear_counts();
        m_ready = 1'b0; s_valid = 1'b1;
        do_start(2'b01, 16'd5);
        for (int k = 0; k < 10; k++) begin
            if (acc_cnt == 2) break;
            cycle();
        end
        abort = 1'b1; start = 1'b1;
        cycle();
        abort = 1'b0; start = 1'b0; s_valid = 1'b0;
        sb.delete();
        chk("t5_aborted", 64'(aborted), 64'd1);
        chk("t5_flushed", {m_valid, busy}, 64'd0);
        chk("t5_shots_in", 64'(shots_in), 64'd2);
        for (int k = 0; k < 4; k++) cycle();
        chk("t5_pulses", {32'(abt_cnt), 32'(done_cnt)}, {32'd1, 32'd0});

        // Full FIFO with simultaneous push/pop, then reset mid-run
        base = 300; clear_counts();
        m_ready = 1'b0; s_valid = 1'b1;
        do_start(2'b00, 16'd200);
        for (int k = 0; k < 10; k++) begin
            if (acc_cnt == 4) break;
            cycle();
        end
        m_ready = 1'b1; both = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (acc_s && pop_s) both++;
        end
        chk("t6_push_pop", 64'(both), 64'd19);
        chk("t6_outputs", 64'(out_cnt), 64'd20);
        reset = 1'b1;
        cycle();
        sb.delete();
        chk("t6_rst_outputs", {s_ready, m_valid, busy, done, aborted, mode_err, m_mode}, 64'd0);
        chk("t6_rst_data", {m_i, m_q}, 64'd0);
        chk("t6_rst_counters", {shots_in, excited_cnt, ground_cnt, online_cnt}, 64'd0);
        reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/analyze_run_ctrl.md
Name: analyze_run_ctrl

Overview:
- Run-level sequencer for the qubit readout analysis path.
- Accepts a stream of per-shot I/Q samples and gates exactly num_shots of them into the analysis engine selected by analyze_mode (data dump, classify, 2D histogram).
- Buffers samples across engine back-pressure and tallies classifier verdicts.
- Signals run completion to host-side readout logic.

Parameters:
- SHOT_W, 16, width of the shot count and all result counters.
- FIFO_DEPTH, 4, sample buffer entries; power of two, minimum 2.
- DATA_W, 32, width of each of i_val and q_val (signed).

Ports:
- clk100  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a run. Honoured only in IDLE.
- abort  in  1  cancels the run in any state.
- analyze_mode  in  2  00 dump, 01 classify, 11 hist2d, 10 illegal. Sampled on start.
- num_shots  in  SHOT_W  number of samples in the run. Sampled on start.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  sample accepted when s_valid && s_ready.
- i_val, q_val  in  DATA_W each  upstream sample.
- m_valid  out  1  sample valid to the analysis engine.
- m_ready  in  1  engine accepts when m_valid && m_ready.
- m_i, m_q  out  DATA_W each  sample at the FIFO head.
- m_mode  out  2  mode latched for the run.
- cls_valid  in  1  classifier verdict strobe.
- cls_result  in  2  01 excited, 10 ground, 00 on-line, 11 ignored.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when an abort takes effect.
- mode_err  out  1  sticky; set by start with mode 10; cleared by the next accepted start.
- shots_in  out  SHOT_W  samples accepted this run.
- excited_cnt, ground_cnt, online_cnt  out  SHOT_W each  classify tallies.

Behaviour:
- Reset: state IDLE, FIFO empty. All outputs 0: s_ready, m_valid, m_i, m_q, m_mode, busy, done, aborted, mode_err and all counters.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - s_ready = 0.
  - start with mode 10: set mode_err, stay in IDLE.
  - start with num_shots = 0 and a legal mode: pulse done the next cycle, stay in IDLE, counters cleared.
  - Any other start: latch mode and num_shots, clear all counters and mode_err, go to RUN.
- RUN:
  - s_ready = !fifo_full && (shots_in < num_shots). It is registered-state based and does not look at m_ready in the same cycle.
  - Each accepted sample is pushed and shots_in increments.
  - Enter DRAIN on the cycle after shots_in reaches num_shots.
- FIFO:
  - m_valid = !fifo_empty; m_i, m_q = head entry.
  - Pop on m_valid && m_ready.
  - A sample accepted at cycle N is visible on m_* at cycle N+1 if the FIFO was empty.
  - Push and pop in the same cycle leave the occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - m_i, m_q are held stable while m_valid && !m_ready.
- Classify tallies:
  - Active only when the latched mode is 01 and busy = 1.
  - cls_valid with 01 / 10 / 00 increments excited / ground / online respectively; 11 is ignored.
  - Counters saturate at all-ones and never wrap.
  - cls_valid is ignored in every other mode and state.
- DRAIN:
  - s_ready = 0.
  - Leave when the FIFO is empty AND, in classify mode only, excited_cnt + ground_cnt + online_cnt = num_shots (checked at SHOT_W+2 bits).
  - Then go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. Counters hold until the next start.
- abort:
  - Highest priority in every state, including same-cycle start or push.
  - Flush the FIFO (m_valid = 0 next cycle) and go to IDLE.
  - Pulse aborted next cycle only if the state was RUN, DRAIN or DONE; done is not pulsed.
  - Counters hold their values.
- start outside IDLE is ignored; the run continues unchanged.
- reset asserted mid-run: next cycle matches the reset state exactly; no done or aborted pulse.

Test Plan:
- Mode 00, num_shots=3, s_valid held high, m_ready=1, samples (1,-1),(2,-2),(3,-3) -> m_* presents those three pairs in order, each one cycle after acceptance. Exactly 3 accepts, then s_ready=0 and done pulses once; shots_in=3.
- Mode 01, num_shots=4, verdicts 01,10,01,00 arriving after samples drain -> done only after the 4th verdict; excited=2, ground=1, online=1.
- Mode 11, num_shots=8, m_ready=0 for the first 10 cycles -> s_ready drops after 4 accepts. m_i, m_q hold stable while stalled; after m_ready=1, all 8 samples come out in order with no loss or duplicates.
- start with mode 10 -> mode_err=1 and state stays IDLE. A following legal start clears mode_err; start with num_shots=0 -> done the next cycle with busy never asserted.
- Mode 01, num_shots=5, abort asserted after 2 accepts, together with start and s_valid -> aborted pulses, m_valid=0 next cycle, IDLE, shots_in=2, no done.
- Push and pop in the same cycle with the FIFO full for 20 cycles (m_ready=1, s_valid=1), then reset high mid-run -> occupancy constant, order preserved, all outputs zero the cycle after reset.
